// File: rtl/policy_shuffler.sv
// In-place Fisher-Yates shuffle of a 17-bit deck driven by an 8-bit Fibonacci LFSR.
// Define SNPU_DOUBLE_PASS_EN to run two back-to-back passes per start (LFSR not reseeded between passes).
module policy_shuffler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  n_cards,
  input  logic [16:0] deck_in,
  input  logic        seed_load,
  input  logic [7:0]  seed,
  output logic [16:0] deck_out,
  output logic        busy,
  output logic        done,
  output logic [4:0]  ones_count
);

  typedef enum logic [1:0] {IDLE, SWAP, DONE} state_t;

  state_t      state_q, state_d;
  logic [16:0] deck_q, deck_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [4:0]  i_q, i_d;
  logic [12:0] prod;
  logic [4:0]  j;
  logic [7:0]  lfsr_step;
`ifdef SNPU_DOUBLE_PASS_EN
  logic        pass_q, pass_d;
  logic [4:0]  n_q, n_d;
`endif

  assign prod      = {5'd0, lfsr_q} * ({8'd0, i_q} + 13'd1);
  assign j         = prod[12:8];
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d = state_q;
    deck_d  = deck_q;
    lfsr_d  = lfsr_q;
    i_d     = i_q;
`ifdef SNPU_DOUBLE_PASS_EN
    pass_d  = pass_q;
    n_d     = n_q;
`endif
    case (state_q)
      IDLE: begin
        if (seed_load) lfsr_d = (seed == 8'd0) ? 8'h01 : seed;
        if (start) begin
          deck_d = deck_in;
          i_d    = n_cards - 5'd1;
`ifdef SNPU_DOUBLE_PASS_EN
          pass_d = 1'b0;
          n_d    = n_cards;
`endif
          // Degenerate sizes bypass SWAP so the LFSR is left untouched.
          if (n_cards < 5'd2 || n_cards > 5'd17) state_d = DONE;
          else                                   state_d = SWAP;
        end
      end
      SWAP: begin
        deck_d[i_q] = deck_q[j];
        deck_d[j]   = deck_q[i_q];
        lfsr_d      = lfsr_step;
        i_d         = i_q - 5'd1;
        if (i_q == 5'd1) begin
`ifdef SNPU_DOUBLE_PASS_EN
          if (!pass_q) begin
            pass_d = 1'b1;
            i_d    = n_q - 5'd1;
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      deck_q  <= 17'd0;
      lfsr_q  <= 8'h01;
      i_q     <= 5'd0;
`ifdef SNPU_DOUBLE_PASS_EN
      pass_q  <= 1'b0;
      n_q     <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      deck_q  <= deck_d;
      lfsr_q  <= lfsr_d;
      i_q     <= i_d;
`ifdef SNPU_DOUBLE_PASS_EN
      pass_q  <= pass_d;
      n_q     <= n_d;
`endif
    end
  end

  assign deck_out = deck_q;
  assign busy     = (state_q == SWAP);
  assign done     = (state_q == DONE);

  always_comb begin
    ones_count = 5'd0;
    for (int k = 0; k < 17; k++) ones_count = ones_count + {4'd0, deck_q[k]};
  end

endmodule

// File: doc/policy_shuffler.md
POLICY_SHUFFLER -- requirements
Module: policy_shuffler

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request a shuffle; sampled only in IDLE.
REQ-004 SHALL have port: n_cards  input  5  number of deck positions to shuffle, counted from bit 0.
REQ-005 SHALL have port: deck_in  input  17  unshuffled deck; bit k is card k.
REQ-006 SHALL have port: seed_load  input  1  load seed into the LFSR; sampled only in IDLE.
REQ-007 SHALL have port: seed  input  8  LFSR seed value.
REQ-008 SHALL have port: deck_out  output  17  shuffled deck; valid while done=1 and until the next start.
REQ-009 SHALL have port: busy  output  1  high in SWAP state.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: ones_count  output  5  combinational popcount of deck_out.

Function
REQ-012 SHALL implement FSM states IDLE, SWAP and DONE: IDLE->SWAP on start; SWAP->DONE after the final swap; DONE->IDLE unconditionally after one cycle.
REQ-013 On the start edge, SHALL load deck_out<=deck_in and set index i<=n_cards-1.
REQ-014 Each SWAP edge SHALL compute j=(lfsr*(i+1))>>8 (8x5 product, 13-bit, upper bits), exchange deck_out[i] and deck_out[j], advance the LFSR one step, and decrement i.
REQ-015 After the swap with i=1, SHALL enter DONE; done SHALL be high exactly n_cards-1 edges after the start edge.
REQ-016 The LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1 (feedback=l[7]^l[5]^l[4]^l[3], shift left, feedback into bit 0), and SHALL advance only on SWAP edges.
REQ-017 seed_load in IDLE SHALL set lfsr<=seed, with seed=0 replaced by 8'h01; start and seed_load on the same edge SHALL use the new seed for the shuffle.
REQ-018 While busy, start and seed_load SHALL be ignored and SHALL NOT be queued.
REQ-019 If n_cards<2 or n_cards>17, start SHALL copy deck_in to deck_out and go directly to DONE, with no swaps and no LFSR advance.
REQ-020 Bits of deck_out at positions >=n_cards SHALL equal deck_in unchanged.
REQ-021 The multiset of bits SHALL be preserved, so ones_count at DONE SHALL equal the popcount of deck_in[n_cards-1:0] plus the untouched bits.
REQ-022 deck_out SHALL hold its value in IDLE and DONE.
REQ-023 deck_in changes after the start edge SHALL NOT affect the shuffle in progress.

Reset
REQ-024 On rst_n low, SHALL set state=IDLE, deck_out=0, busy=0, done=0, lfsr=8'h01 and i=0, asynchronously.
REQ-025 Reset asserted mid-SWAP SHALL abort the shuffle with no done pulse and restore all reset values.
REQ-026 After rst_n deasserts, the first edge SHALL be able to accept start.

Configuration
REQ-027 Macro SNPU_DOUBLE_PASS_EN SHALL control whether a second shuffle pass is performed.
REQ-028 With SNPU_DOUBLE_PASS_EN defined, after the first pass SHALL reload i<=n_cards-1 and run a second pass, with the LFSR continuing (not reseeded); done SHALL occur 2*(n_cards-1) edges after start, and busy SHALL stay high continuously.
REQ-029 Without SNPU_DOUBLE_PASS_EN, the block SHALL perform a single pass per REQ-015.

Verification
REQ-030 Reset check: assert rst_n=0 mid-shuffle -> deck_out=0, busy=0, done=0 immediately; no done pulse follows.
REQ-031 Two-card shuffle: seed_load seed=8'h01 then start, n_cards=2, deck_in=17'b01 -> j=(1*2)>>8=0, swap gives deck_out=17'b10; done high 1 edge after start; lfsr=8'h02.
REQ-032 Full 17-card shuffle: deck_in=17'h0003F, n_cards=17, seed=8'hA5 -> done exactly 16 edges after start (32 with SNPU_DOUBLE_PASS_EN); ones_count=6; repeating with the same seed gives an identical deck_out.
REQ-033 Partial shuffle: n_cards=8, deck_in=17'h1FF00 -> deck_out[16:8]=9'h1FF unchanged; done 7 edges after start.
REQ-034 Illegal size: n_cards=0 or 18, deck_in=17'h12345 -> deck_out=17'h12345, done 1 edge after start, lfsr unchanged.
REQ-035 Busy protection: pulse start and seed_load=8'hFF while busy -> no restart; result equals the run without the pulses.
